// File: rtl/matrix_row_gen.sv
// Two-row line buffer that turns a raster pixel stream into vertically aligned
// top/middle/bottom columns for a 3x3 morphology kernel.
module matrix_row_gen #(
  parameter logic [10:0] PIC_WIDTH  = 11'd250,
  parameter logic [10:0] PIC_HEIGHT = 11'd250,
  parameter int          WIDTH      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             frame_done
);

  localparam int AW = $clog2(int'(PIC_WIDTH));

  logic [WIDTH-1:0] mem0 [int'(PIC_WIDTH)];
  logic [WIDTH-1:0] mem1 [int'(PIC_WIDTH)];

  logic [10:0]   col_cnt;
  logic [10:0]   row_cnt;
  logic [10:0]   col_p0;
  logic [10:0]   row_p0;
  logic [AW-1:0] addr_p0;
  logic          last_col_p0;
  logic          last_row_p0;

  // Stage p0: effective position of the incoming pixel (frame_start forces 0,0)
  always_comb begin
    col_p0      = frame_start ? 11'd0 : col_cnt;
    row_p0      = frame_start ? 11'd0 : row_cnt;
    addr_p0     = col_p0[AW-1:0];
    last_col_p0 = (col_p0 == PIC_WIDTH - 11'd1);
    last_row_p0 = (row_p0 == PIC_HEIGHT - 11'd1);
  end

  // Row memories shift down one row per accept; old contents are read first
  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem0[addr_p0] <= mem1[addr_p0];
      mem1[addr_p0] <= din;
    end
  end

  // Stage p1: registered column outputs and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      dout1      <= '0;
      dout2      <= '0;
      dout3      <= '0;
    end else if (valid_in) begin
      dout1      <= mem0[addr_p0];
      dout2      <= mem1[addr_p0];
      dout3      <= din;
      valid_out  <= (row_p0 >= 11'd2);
      frame_done <= last_col_p0 && last_row_p0;
      if (last_col_p0) begin
        col_cnt <= '0;
        row_cnt <= last_row_p0 ? 11'd0 : row_p0 + 11'd1;
      end else begin
        col_cnt <= col_p0 + 11'd1;
        row_cnt <= row_p0;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_row_gen.sv
// Self-checking bench for matrix_row_gen on a 4x4 frame, pixel = row*16 + col.
module tb_matrix_row_gen;

  localparam int W = 24;
  localparam logic [W-1:0] ALL1 = 24'hFFFFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         frame_start;
  logic [W-1:0] din;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3;
  logic         frame_done;

  always #5 clk = ~clk;

  matrix_row_gen #(.PIC_WIDTH(11'd4), .PIC_HEIGHT(11'd4), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .frame_start(frame_start),
    .din(din), .valid_out(valid_out), .dout1(dout1), .dout2(dout2),
    .dout3(dout3), .frame_done(frame_done)
  );

  typedef struct {
    logic v; logic fd;
    logic [W-1:0] d1; logic [W-1:0] d2; logic [W-1:0] d3;
    bit k1; bit k2; bit k3;
  } exp_t;

  typedef struct {
    logic [W-1:0] d1; logic [W-1:0] d2; logic [W-1:0] d3;
  } col_t;

  exp_t sbq[$];
  exp_t cur;
  logic [W-1:0] m0 [4];
  logic [W-1:0] m1 [4];
  bit k0 [4];
  bit k1 [4];
  int mr, mc;

  int n_vec = 0;
  int n_bad = 0;
  int fd_n;
  bit in_b;
  col_t cap[$];
  col_t tbl[8];

  function automatic logic [W-1:0] pix(input int r, input int c);
    return W'(r * 16 + c);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    cur = '{v: 1'b0, fd: 1'b0, d1: '0, d2: '0, d3: '0, k1: 1'b1, k2: 1'b1, k3: 1'b1};
    for (int i = 0; i < 4; i++) begin k0[i] = 1'b0; k1[i] = 1'b0; end
  endtask

  task automatic step(input logic v, input logic fs, input logic [W-1:0] d);
    exp_t e;
    int r, c;
    valid_in = v; frame_start = fs; din = d;
    if (v) begin
      c = fs ? 0 : mc;
      r = fs ? 0 : mr;
      cur.d3 = d;     cur.k3 = 1'b1;
      cur.d1 = m0[c]; cur.k1 = k0[c];
      cur.d2 = m1[c]; cur.k2 = k1[c];
      m0[c] = m1[c];  k0[c] = k1[c];
      m1[c] = d;      k1[c] = 1'b1;
      cur.v  = (r >= 2);
      cur.fd = (r == 3 && c == 3);
      if (c == 3) begin mc = 0; mr = (r == 3) ? 0 : r + 1; end
      else begin mc = c + 1; mr = r; end
    end else begin
      cur.v = 1'b0; cur.fd = 1'b0;
    end
    sbq.push_back(cur);
    @(posedge clk); #1;
    e = sbq.pop_front();
    check("valid_out", W'(valid_out), W'(e.v));
    check("frame_done", W'(frame_done), W'(e.fd));
    if (e.k3) check("dout3", dout3, e.d3);
    if (e.k2) check("dout2", dout2, e.d2);
    if (e.k1) check("dout1", dout1, e.d1);
    if (valid_out) cap.push_back('{d1: dout1, d2: dout2, d3: dout3});
    if (frame_done) fd_n++;
    if (in_b)
      check("stale_ff", W'(valid_out && (dout1 == ALL1 || dout2 == ALL1 || dout3 == ALL1)), '0);
  endtask

  task automatic send_frame(input bit ff);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        step(1'b1, (r == 0 && c == 0), ff ? ALL1 : pix(r, c));
  endtask

  task automatic cmp_cap(input string name, input int off, input int n);
    check({name, "_count"}, W'(cap.size()), W'(n));
    for (int i = 0; i < n && i < cap.size(); i++) begin
      check({name, "_d1"}, cap[i].d1, tbl[off + i].d1);
      check({name, "_d2"}, cap[i].d2, tbl[off + i].d2);
      check({name, "_d3"}, cap[i].d3, tbl[off + i].d3);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid_out"}, W'(valid_out), '0);
    check({name, "_frame_done"}, W'(frame_done), '0);
    check({name, "_dout1"}, dout1, '0);
    check({name, "_dout2"}, dout2, '0);
    check({name, "_dout3"}, dout3, '0);
  endtask

  initial begin
    tbl[0] = '{d1: 24'h00, d2: 24'h10, d3: 24'h20};
    tbl[1] = '{d1: 24'h01, d2: 24'h11, d3: 24'h21};
    tbl[2] = '{d1: 24'h02, d2: 24'h12, d3: 24'h22};
    tbl[3] = '{d1: 24'h03, d2: 24'h13, d3: 24'h23};
    tbl[4] = '{d1: 24'h10, d2: 24'h20, d3: 24'h30};
    tbl[5] = '{d1: 24'h11, d2: 24'h21, d3: 24'h31};
    tbl[6] = '{d1: 24'h12, d2: 24'h22, d3: 24'h32};
    tbl[7] = '{d1: 24'h13, d2: 24'h23, d3: 24'h33};
    in_b = 1'b0; fd_n = 0;
    rst_n = 1'b0; valid_in = 1'b0; frame_start = 1'b0; din = '0;
    model_reset();

    // Reset with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      frame_start = 1'($urandom_range(0, 1));
      din = W'($urandom);
      @(posedge clk); #1;
      check_zero("reset");
    end
    valid_in = 1'b0; frame_start = 1'b0;
    rst_n = 1'b1;

    // Full continuous frame
    cap.delete(); fd_n = 0;
    send_frame(1'b0);
    step(1'b0, 1'b0, '0);
    cmp_cap("full", 0, 8);
    check("full_frame_done_count", W'(fd_n), W'(1));

    // Gap after (2,1)
    cap.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4 && !(r == 2 && c == 2); c++)
        step(1'b1, (r == 0 && c == 0), pix(r, c));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'h5A5A5A);
    step(1'b1, 1'b0, pix(2, 2));
    check("gap_resume_d1", dout1, 24'h02);
    check("gap_resume_d2", dout2, 24'h12);
    check("gap_resume_d3", dout3, 24'h22);
    step(1'b1, 1'b0, pix(2, 3));
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, pix(3, c));
    cmp_cap("gap", 0, 8);

    // frame_start at what would be (2,2)
    fd_n = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4 && !(r == 2 && c == 2); c++)
        step(1'b1, (r == 0 && c == 0), pix(r, c) | 24'h800);
    cap.delete();
    send_frame(1'b0);
    cmp_cap("restart", 0, 8);
    check("restart_frame_done_count", W'(fd_n), W'(1));

    // Back-to-back frames, stale all-ones must never surface
    send_frame(1'b1);
    cap.delete(); in_b = 1'b1;
    send_frame(1'b0);
    in_b = 1'b0;
    cmp_cap("b2b", 0, 8);

    // Reset during row 3
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4 && !(r == 3 && c == 2); c++)
        step(1'b1, (r == 0 && c == 0), pix(r, c));
    valid_in = 1'b0; frame_start = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap.delete();
    send_frame(1'b0);
    cmp_cap("after_reset", 0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
